aes256_key_sched_ctrl: RTL

//  Sequences the AES-256 key expansion: latches a 256-bit cipher key and generates all 15 128-bit round keys (rounds 0..14).

---
 rtl/aes256_key_sched_ctrl_pkg.sv | 27 ++
 rtl/aes256_key_word_calc.sv | 33 +++
 rtl/aes256_key_sched_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aes256_key_sched_ctrl_pkg.sv
// Shared constants, state encoding and byte/word helpers for the AES-256 key schedule controller.
// Imported by the top-level sequencer and by the round-key word calculator.
package aes256_key_sched_ctrl_pkg;

  localparam int NR    = 14;
  localparam int KEY_W = 256;
  localparam int RK_W  = 128;

  localparam logic [7:0] RCON_INIT = 8'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes256_key_word_calc.sv
// Combinational generator for one 128-bit AES-256 round key from the key two rounds back,
// the substituted last word of the previous key, and the current round constant.
module aes256_key_word_calc
  import aes256_key_sched_ctrl_pkg::*;
(
  input  logic [RK_W-1:0] prev0_i,
  input  logic [31:0]     sboxOut_i,
  input  logic [7:0]      rcon_i,
  input  logic            roundOdd_i,
  output logic [RK_W-1:0] newKey_o
);

  logic [31:0] tWord;
  logic [31:0] k0;
  logic [31:0] k1;
  logic [31:0] k2;
  logic [31:0] k3;

  // Even rounds start a new 8-word group (RotWord + Rcon); odd rounds use SubWord alone.
  // RotWord after the byte-wise S-box equals RotWord before it, so the S-box sees the unrotated word.
  always_comb begin
    tWord = sboxOut_i;
    if (!roundOdd_i) begin
      tWord = rot_word(sboxOut_i) ^ {rcon_i, 24'h000000};
    end
    k0       = prev0_i[127:96] ^ tWord;
    k1       = prev0_i[95:64]  ^ k0;
    k2       = prev0_i[63:32]  ^ k1;
    k3       = prev0_i[31:0]   ^ k2;
    newKey_o = {k0, k1, k2, k3};
  end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// AES-256 key expansion sequencer: latches the cipher key, borrows the shared S-box word path
// through req/gnt, and fills a 15-entry round-key file that the cipher rounds read combinationally.
module aes256_key_sched_ctrl
  import aes256_key_sched_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [KEY_W-1:0] key_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [3:0]       keys_avail_o,
  output logic             sbox_req_o,
  output logic [31:0]      sbox_in_o,
  input  logic             sbox_gnt_i,
  input  logic [31:0]      sbox_out_i,
  input  logic [3:0]       rk_rd_idx_i,
  output logic [RK_W-1:0]  rk_rd_data_o,
  output logic             rk_rd_valid_o
);

  state_e          state_q;
  logic [RK_W-1:0] prev0_q;
  logic [RK_W-1:0] prev1_q;
  logic [3:0]      round_q;
  logic [7:0]      rcon_q;
  logic [3:0]      keysAvail_q;
  logic            busy_q;
  logic            done_q;
  logic            sboxReq_q;
  logic [31:0]     sboxIn_q;
  logic [RK_W-1:0] rkFile_q [NR+1];

  logic [RK_W-1:0] newKey_d;
  logic            rdValid;
  logic [RK_W-1:0] rdData;

  aes256_key_word_calc u_wordCalc (
    .prev0_i    (prev0_q),
    .sboxOut_i  (sbox_out_i),
    .rcon_i     (rcon_q),
    .roundOdd_i (round_q[0]),
    .newKey_o   (newKey_d)
  );

  // Sequencer: one REQ/CALC pair per generated round key. The S-box input is registered when
  // entering REQ so it cannot move while the request is pending, however long the grant takes.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      prev0_q     <= '0;
      prev1_q     <= '0;
      round_q     <= '0;
      rcon_q      <= RCON_INIT;
      keysAvail_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sboxReq_q   <= 1'b0;
      sboxIn_q    <= '0;
      for (int i = 0; i <= NR; i++) begin
        rkFile_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i) begin
            state_q     <= REQ;
            prev0_q     <= key_i[KEY_W-1:RK_W];
            prev1_q     <= key_i[RK_W-1:0];
            rkFile_q[0] <= key_i[KEY_W-1:RK_W];
            rkFile_q[1] <= key_i[RK_W-1:0];
            keysAvail_q <= 4'd2;
            round_q     <= 4'd2;
            rcon_q      <= RCON_INIT;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            sboxReq_q   <= 1'b1;
            sboxIn_q    <= key_i[31:0];
          end
        end
        REQ: begin
          if (sbox_gnt_i) begin
            state_q   <= CALC;
            sboxReq_q <= 1'b0;
          end
        end
        CALC: begin
          rkFile_q[round_q] <= newKey_d;
          prev0_q           <= prev1_q;
          prev1_q           <= newKey_d;
          keysAvail_q       <= keysAvail_q + 4'd1;
          round_q           <= round_q + 4'd1;
          if (round_q[0]) begin
            rcon_q <= xtime(rcon_q);
          end
          if (round_q < 4'(NR)) begin
            state_q   <= REQ;
            sboxReq_q <= 1'b1;
            sboxIn_q  <= newKey_d[31:0];
          end else begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Entries at or above keys_avail read as zero, so stale keys from an earlier expansion never leak.
  always_comb begin
    rdValid = (rk_rd_idx_i < keysAvail_q);
    rdData  = '0;
    if (rdValid) begin
      rdData = rkFile_q[rk_rd_idx_i];
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign keys_avail_o  = keysAvail_q;
  assign sbox_req_o    = sboxReq_q;
  assign sbox_in_o     = sboxIn_q;
  assign rk_rd_data_o  = rdData;
  assign rk_rd_valid_o = rdValid;

endmodule
